// File: rtl/serial_port_router.sv
// Serial frame router: start bit, MSB-first port and length fields, payload, optional
// even-parity bit. Payload bits are steered to one of 2**PORT_BITS strobed outputs.
module serial_port_router #(
  parameter int PORT_BITS = 2,
  parameter int LEN_BITS  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clkEn,
  input  logic                      serIn,
  output logic [2**PORT_BITS-1:0]   pOut,
  output logic [2**PORT_BITS-1:0]   pValid,
  output logic [LEN_BITS-1:0]       remCnt,
  output logic                      busy,
  output logic                      done,
  output logic                      frameErr,
  output logic [6:0]                SSDout
);

  localparam int NUM_PORTS = 2**PORT_BITS;
  localparam int CNT_W     = $clog2(PORT_BITS > LEN_BITS ? PORT_BITS : LEN_BITS) + 1;
  localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_BITS - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_BITS - 1);
  localparam logic PAR_ON = (PARITY_EN != 0);

  typedef enum logic [2:0] {S_IDLE, S_PORT, S_LEN, S_DATA, S_PAR, S_DONE} state_t;

  state_t                 state, state_next;
  logic [PORT_BITS-1:0]   port_q;
  logic [LEN_BITS-1:0]    len_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   pxor;

  logic [PORT_BITS-1:0]   port_shift;
  logic [LEN_BITS-1:0]    len_shift;
  logic [NUM_PORTS-1:0]   onehot;
  logic                   port_last, len_last;
  logic [3:0]             nib;

  // The field value including the bit being sampled on this edge.
  assign port_shift = (port_q << 1) | PORT_BITS'(serIn);
  assign len_shift  = (len_q << 1)  | LEN_BITS'(serIn);
  assign onehot     = NUM_PORTS'(1) << port_q;
  assign port_last  = (bit_cnt == PORT_LAST);
  assign len_last   = (bit_cnt == LEN_LAST);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE: if (clkEn && !serIn) state_next = S_PORT;
      S_PORT: if (clkEn && port_last) state_next = S_LEN;
      S_LEN:
        if (clkEn && len_last) begin
          if (len_shift != '0) state_next = S_DATA;
          else                 state_next = PAR_ON ? S_PAR : S_DONE;
        end
      S_DATA: if (clkEn && remCnt == LEN_BITS'(1)) state_next = PAR_ON ? S_PAR : S_DONE;
      S_PAR:  if (clkEn) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register sees
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q   <= '0;
      len_q    <= '0;
      bit_cnt  <= '0;
      pxor     <= 1'b0;
      pOut     <= '0;
      pValid   <= '0;
      remCnt   <= '0;
      frameErr <= 1'b0;
    end else begin
      // Strobe is single-cycle regardless of clkEn.
      pValid <= '0;
      if (clkEn) begin
        case (state)
          S_IDLE:
            if (!serIn) begin
              bit_cnt <= '0;
              pxor    <= 1'b0;
            end
          S_PORT: begin
            port_q  <= port_shift;
            bit_cnt <= port_last ? '0 : bit_cnt + 1'b1;
          end
          S_LEN: begin
            len_q   <= len_shift;
            bit_cnt <= bit_cnt + 1'b1;
            if (len_last) remCnt <= len_shift;
          end
          S_DATA: begin
            pOut   <= serIn ? onehot : '0;
            pValid <= onehot;
            remCnt <= remCnt - 1'b1;
            pxor   <= pxor ^ serIn;
          end
          S_PAR: frameErr <= serIn ^ pxor;
          default: ;
        endcase
        // Without a parity phase the frame status is always clean.
        if (state != S_PAR && state_next == S_DONE) frameErr <= 1'b0;
      end
    end
  end

  assign nib = 4'(remCnt);

  always_comb begin
    case (nib)
      4'h0: SSDout = 7'h3F;
      4'h1: SSDout = 7'h06;
      4'h2: SSDout = 7'h5B;
      4'h3: SSDout = 7'h4F;
      4'h4: SSDout = 7'h66;
      4'h5: SSDout = 7'h6D;
      4'h6: SSDout = 7'h7D;
      4'h7: SSDout = 7'h07;
      4'h8: SSDout = 7'h7F;
      4'h9: SSDout = 7'h6F;
      4'hA: SSDout = 7'h77;
      4'hB: SSDout = 7'h7C;
      4'hC: SSDout = 7'h39;
      4'hD: SSDout = 7'h5E;
      4'hE: SSDout = 7'h79;
      default: SSDout = 7'h71;
    endcase
  end

endmodule

// File: tb/tb_serial_port_router.sv
// Bench for serial_port_router: default instance (a) and PORT_BITS=3 / no-parity instance (b),
// with scoreboards of expected strobes and done pulses checked by a negedge monitor.
module tb_serial_port_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clkEn_a, serIn_a, clkEn_b, serIn_b;
  logic [3:0] pOut_a, pValid_a, remCnt_a, remCnt_b;
  logic [7:0] pOut_b, pValid_b;
  logic       busy_a, done_a, frameErr_a, busy_b, done_b, frameErr_b;
  logic [6:0] SSDout_a, SSDout_b;

  serial_port_router dut_a (
    .clk(clk), .rst(rst), .clkEn(clkEn_a), .serIn(serIn_a),
    .pOut(pOut_a), .pValid(pValid_a), .remCnt(remCnt_a), .busy(busy_a),
    .done(done_a), .frameErr(frameErr_a), .SSDout(SSDout_a)
  );

  serial_port_router #(.PORT_BITS(3), .LEN_BITS(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .clkEn(clkEn_b), .serIn(serIn_b),
    .pOut(pOut_b), .pValid(pValid_b), .remCnt(remCnt_b), .busy(busy_b),
    .done(done_b), .frameErr(frameErr_b), .SSDout(SSDout_b)
  );

  typedef struct packed {
    logic [7:0] pv;
    logic [7:0] po;
    logic [3:0] rc;
  } beat_t;

  beat_t qa[$], qb[$];
  logic  da[$], db[$];
  beat_t ea, eb;
  logic  fa, fb;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ssd(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // Monitor: every strobe or done pulse must match the head of its scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (pValid_a !== 4'b0) begin
        if (qa.size() == 0) check("pvalid_a_unexpected", pValid_a, 0);
        else begin
          ea = qa.pop_front();
          check("pvalid_a", pValid_a, ea.pv);
          check("pout_a", pOut_a, ea.po);
          check("remcnt_a", remCnt_a, ea.rc);
        end
      end
      if (pValid_b !== 8'b0) begin
        if (qb.size() == 0) check("pvalid_b_unexpected", pValid_b, 0);
        else begin
          eb = qb.pop_front();
          check("pvalid_b", pValid_b, eb.pv);
          check("pout_b", pOut_b, eb.po);
          check("remcnt_b", remCnt_b, eb.rc);
        end
      end
      if (done_a === 1'b1) begin
        if (da.size() == 0) check("done_a_unexpected", done_a, 0);
        else begin
          fa = da.pop_front();
          check("frameerr_a", frameErr_a, fa);
        end
      end
      if (done_b === 1'b1) begin
        if (db.size() == 0) check("done_b_unexpected", done_b, 0);
        else begin
          fb = db.pop_front();
          check("frameerr_b", frameErr_b, fb);
        end
      end
    end
  end

  // One bit on serIn, held for gap disabled cycles followed by one enabled edge.
  task automatic send(input int which, input logic b, input int gap);
    if (which == 0) begin serIn_a = b; clkEn_a = 1'b0; end
    else            begin serIn_b = b; clkEn_b = 1'b0; end
    repeat (gap) begin @(posedge clk); #1; end
    if (which == 0) clkEn_a = 1'b1; else clkEn_b = 1'b1;
    @(posedge clk); #1;
    if (which == 0) clkEn_a = 1'b0; else clkEn_b = 1'b0;
  endtask

  // Drives a frame; stop_after >= 0 abandons it before that data bit.
  task automatic frame(input int which, input int port, input int len, input logic [15:0] data,
                       input logic par, input int gap, input int stop_after);
    int         pb;
    logic       xr;
    logic [7:0] oh;
    beat_t      e;
    pb = (which == 0) ? 2 : 3;
    xr = 1'b0;
    oh = 8'(1) << port;
    send(which, 1'b0, gap);
    for (int i = pb - 1; i >= 0; i--) send(which, port[i], gap);
    for (int i = 3; i >= 0; i--) send(which, len[i], gap);
    check("remcnt_load", (which == 0) ? remCnt_a : remCnt_b, len);
    check("ssd_load", (which == 0) ? SSDout_a : SSDout_b, ssd(4'(len)));
    for (int i = 0; i < len; i++) begin
      if (i == stop_after) return;
      e.pv = oh;
      e.po = data[i] ? oh : 8'h00;
      e.rc = 4'(len - 1 - i);
      if (which == 0) qa.push_back(e); else qb.push_back(e);
      send(which, data[i], gap);
      xr = xr ^ data[i];
    end
    if (which == 0) begin
      da.push_back(par ^ xr);
      send(0, par, gap);
    end else begin
      db.push_back(1'b0);
    end
    check("done_latency", (which == 0) ? done_a : done_b, 1);
    send(which, 1'b1, 0);
    send(which, 1'b1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    serIn_a = 1'b1; clkEn_a = 1'b0;
    serIn_b = 1'b1; clkEn_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ssd", SSDout_a, 7'h3F);
    check("rst_busy", busy_a, 0);
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset mid-cycle while inside PORT.
    @(posedge clk); #1;
    send(0, 1'b0, 0);
    send(0, 1'b1, 0);
    check("busy_in_port", busy_a, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_pout", pOut_a, 0);
    check("arst_pvalid", pValid_a, 0);
    check("arst_remcnt", remCnt_a, 0);
    check("arst_done", done_a, 0);
    check("arst_frameerr", frameErr_a, 0);
    check("arst_ssd", SSDout_a, 7'h3F);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Nominal frame: port 2, length 3, data 1,0,1, parity 0.
    frame(0, 2, 3, 16'b101, 1'b0, 0, -1);
    check("nominal_remcnt_idle", remCnt_a, 0);
    check("nominal_pout_held", pOut_a, 4'b0100);
    check("nominal_busy_idle", busy_a, 0);

    // Parity error, status held until the next frame's done.
    frame(0, 2, 3, 16'b101, 1'b1, 0, -1);
    repeat (3) send(0, 1'b1, 0);
    check("frameerr_held", frameErr_a, 1);
    check("done_low_between", done_a, 0);

    // Zero-length frame clears the error.
    frame(0, 1, 0, 16'b0, 1'b0, 0, -1);
    check("zero_len_frameerr", frameErr_a, 0);

    // clkEn high one cycle in four.
    frame(0, 2, 3, 16'b101, 1'b0, 3, -1);

    // Variant instance: reset after the second data bit, then a clean frame.
    frame(1, 5, 4, 16'b1111, 1'b0, 0, 2);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("b_rst_busy", busy_b, 0);
    check("b_rst_remcnt", remCnt_b, 0);
    check("b_rst_pvalid", pValid_b, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    frame(1, 5, 2, 16'b11, 1'b0, 0, -1);
    check("b_pout_held", pOut_b, 8'b00100000);
    check("b_frameerr", frameErr_b, 0);

    repeat (4) @(posedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("da_drained", da.size(), 0);
    check("db_drained", db.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
